// File: rtl/icache_pkg.sv
// Shared types for the instruction cache: address split, frame layout and FSM states.
package icache_pkg;

  localparam int ICACHE_IDX_W   = 4;
  localparam int ICACHE_NFRAMES = 1 << ICACHE_IDX_W;
  localparam int ICACHE_TAG_W   = 32 - ICACHE_IDX_W - 2;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    logic [31:0]             data;
  } icache_frame_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Fetch-side (datapath_cache_if) and memory-side (caches_if) bundles of the instruction cache.
interface datapath_cache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;

  modport icache   (input imemREN, imemaddr, output ihit, imemload);
  modport datapath (output imemREN, imemaddr, input ihit, imemload);
endinterface

interface caches_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport icache (output iREN, iaddr, input iwait, iload);
  modport mem    (input iREN, iaddr, output iwait, iload);
endinterface

// File: rtl/icache_perf.sv
// Hit/miss event counters for the instruction cache; only built with ICACHE_PERF_EN defined.
`ifdef ICACHE_PERF_EN
module icache_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_hit,
  input  logic        i_miss,
  output logic [31:0] o_hit_count,
  output logic [31:0] o_miss_count
);

  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (i_hit)  r_hit_count  <= r_hit_count + 32'd1;
      if (i_miss) r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;

endmodule
`endif

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, one word per frame, combinational hits.
// Defining ICACHE_PERF_EN adds o_hit_count / o_miss_count via icache_perf.
module icache
  import icache_pkg::*;
#(
  parameter int NFRAMES = ICACHE_NFRAMES,  // keep consistent with icache_pkg
  parameter int IDX_W   = ICACHE_IDX_W
) (
  input logic              clk,
  input logic              rst_n,
  datapath_cache_if.icache dcif,
  caches_if.icache         cif
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]      o_hit_count,
  output logic [31:0]      o_miss_count
`endif
);

  icache_state_t    r_state;
  icache_state_t    w_state_next;
  icache_frame_t    r_frames [NFRAMES];
  icachef_t         r_miss_addr;
  logic [IDX_W-1:0] w_idx;
  logic [29-IDX_W:0] w_tag;
  logic             w_hit;
  logic             w_miss_start;
  logic             w_fill_done;
  logic             w_unused_bytoff;

  assign w_idx           = dcif.imemaddr[IDX_W+1:2];
  assign w_tag           = dcif.imemaddr[31:IDX_W+2];
  assign w_unused_bytoff = ^dcif.imemaddr[1:0];

  assign w_hit = dcif.imemREN && r_frames[w_idx].valid && (r_frames[w_idx].tag == w_tag);
  assign dcif.imemload = w_hit ? r_frames[w_idx].data : '0;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: every output is defaulted first so no path leaves a value held, which would infer a latch.
  always_comb begin
    w_state_next = r_state;
    dcif.ihit    = 1'b0;
    cif.iREN     = 1'b0;
    cif.iaddr    = '0;
    w_miss_start = 1'b0;
    w_fill_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        dcif.ihit = w_hit;
        if (dcif.imemREN && !w_hit) begin
          w_miss_start = 1'b1;
          w_state_next = FILL;
        end
      end
      FILL: begin
        cif.iREN  = 1'b1;
        cif.iaddr = r_miss_addr;
        if (!cif.iwait) begin
          w_fill_done  = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Miss address is captured once on entry to FILL; fetch redirects cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miss_addr <= '0;
    end else if (w_miss_start) begin
      r_miss_addr <= '{tag: w_tag, idx: w_idx, bytoff: 2'b00};
    end
  end

  // NOTE: the frame array is reset in full because valid bits must clear on reset and the array is flops, not SRAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NFRAMES; i++) r_frames[i] <= '0;
    end else if (w_fill_done) begin
      r_frames[r_miss_addr.idx] <= '{valid: 1'b1, tag: r_miss_addr.tag, data: cif.iload};
    end
  end

`ifdef ICACHE_PERF_EN
  icache_perf u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_hit        (dcif.ihit),
    .i_miss       (w_miss_start),
    .o_hit_count  (o_hit_count),
    .o_miss_count (o_miss_count)
  );
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table, hand-written corner sequences,
// and randomized fetches checked against a frame-level reference model.
module tb_icache;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  datapath_cache_if dcif ();
  caches_if         cif ();

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dcif  (dcif.icache),
    .cif   (cif.icache)
`ifdef ICACHE_PERF_EN
    ,
    .o_hit_count  (hit_count),
    .o_miss_count (miss_count)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] addr;
    int          wait_n;
    logic [31:0] load;
    logic        exp_hit;
    logic [31:0] exp_data;
    logic        redirect;
  } vec_t;

  vec_t vecs [13];

  // Reference model: one entry per index holding the cached word address and data.
  bit          m_valid [16];
  logic [31:0] m_addr  [16];
  logic [31:0] m_data  [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  // Called at a falling edge; returns at a falling edge.
  task automatic do_reset();
    rst_n         = 1'b0;
    dcif.imemREN  = 1'b0;
    dcif.imemaddr = '0;
    cif.iwait     = 1'b1;
    cif.iload     = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One fetch transaction: request cycle, optional fill cycles, and the post-fill hit cycle.
  task automatic do_fetch(input logic [31:0] addr, input int wait_n, input logic [31:0] load,
                          input logic exp_hit, input logic [31:0] exp_data, input logic redirect);
    dcif.imemREN  = 1'b1;
    dcif.imemaddr = addr;
    cif.iwait     = 1'b1;
    cif.iload     = '0;
    #1;
    check("req_ihit", 32'(dcif.ihit), 32'(exp_hit));
    check("req_iren", 32'(cif.iREN), 32'd0);
    check("req_load", dcif.imemload, exp_hit ? exp_data : 32'd0);
    @(negedge clk);
    if (!exp_hit) begin
      for (int k = 0; k <= wait_n; k++) begin
        if (redirect && k == 0) begin
          dcif.imemaddr = addr ^ 32'h0000_0100;
          dcif.imemREN  = 1'($urandom_range(0, 1));
        end
        cif.iwait = (k < wait_n);
        cif.iload = (k < wait_n) ? (32'hBAD0_0000 | 32'(k)) : load;
        #1;
        check("fill_iren",  32'(cif.iREN), 32'd1);
        check("fill_iaddr", cif.iaddr, addr & ~32'h3);
        check("fill_ihit",  32'(dcif.ihit), 32'd0);
        @(negedge clk);
      end
      dcif.imemREN  = 1'b1;
      dcif.imemaddr = addr;
      cif.iwait     = 1'b1;
      cif.iload     = '0;
      #1;
      check("post_ihit", 32'(dcif.ihit), 32'd1);
      check("post_load", dcif.imemload, exp_data);
      check("post_iren", 32'(cif.iREN), 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] ld;
    logic        eh;
    int          ix;

    vecs[0]  = '{32'h0000_0040, 3, 32'h2001_0005, 1'b0, 32'h2001_0005, 1'b0};  // cold miss
    vecs[1]  = '{32'h0000_0040, 0, 32'h0,         1'b1, 32'h2001_0005, 1'b0};  // warm hit
    vecs[2]  = '{32'h0000_0440, 0, 32'hDEAD_0440, 1'b0, 32'hDEAD_0440, 1'b0};  // conflict evicts 0x40
    vecs[3]  = '{32'h0000_0040, 1, 32'h2001_0005, 1'b0, 32'h2001_0005, 1'b0};  // 0x40 misses again
    vecs[4]  = '{32'h0000_0044, 2, 32'h1111_0044, 1'b0, 32'h1111_0044, 1'b0};
    vecs[5]  = '{32'h0000_007C, 0, 32'h7C7C_007C, 1'b0, 32'h7C7C_007C, 1'b0};  // last index
    vecs[6]  = '{32'h0000_0044, 0, 32'h0,         1'b1, 32'h1111_0044, 1'b0};
    vecs[7]  = '{32'h0000_007C, 0, 32'h0,         1'b1, 32'h7C7C_007C, 1'b0};
    vecs[8]  = '{32'hFFFF_FFFC, 2, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0};  // max tag, idx 15
    vecs[9]  = '{32'h0000_007C, 0, 32'h7C7C_007C, 1'b0, 32'h7C7C_007C, 1'b0};
    vecs[10] = '{32'h0000_0043, 0, 32'h0,         1'b1, 32'h2001_0005, 1'b0};  // byte offset ignored
    vecs[11] = '{32'hFFFF_FFFC, 1, 32'hFEED_FFFC, 1'b0, 32'hFEED_FFFC, 1'b0};
    vecs[12] = '{32'h0000_0044, 0, 32'h0,         1'b1, 32'h1111_0044, 1'b0};

    // Reset state, with a request already presented.
    dcif.imemREN  = 1'b1;
    dcif.imemaddr = 32'h0000_0040;
    cif.iwait     = 1'b1;
    cif.iload     = 32'hFFFF_FFFF;
    #1 rst_n = 1'b0;
    #2;
    check("rst_ihit",  32'(dcif.ihit), 32'd0);
    check("rst_load",  dcif.imemload, 32'd0);
    check("rst_iren",  32'(cif.iREN), 32'd0);
    check("rst_iaddr", cif.iaddr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++)
      do_fetch(vecs[i].addr, vecs[i].wait_n, vecs[i].load, vecs[i].exp_hit,
               vecs[i].exp_data, vecs[i].redirect);

    // Redirect mid-fill: iaddr holds 0x80, then 0x100 misses afterwards.
    dcif.imemREN  = 1'b1;
    dcif.imemaddr = 32'h0000_0080;
    cif.iwait     = 1'b1;
    #1;
    check("redir_req_ihit", 32'(dcif.ihit), 32'd0);
    @(negedge clk);
    dcif.imemaddr = 32'h0000_0100;
    for (int k = 0; k < 3; k++) begin
      cif.iwait = (k < 2);
      cif.iload = 32'h0800_0080;
      #1;
      check("redir_iaddr", cif.iaddr, 32'h0000_0080);
      check("redir_iren",  32'(cif.iREN), 32'd1);
      @(negedge clk);
    end
    do_fetch(32'h0000_0100, 1, 32'h1000_0100, 1'b0, 32'h1000_0100, 1'b0);
    do_fetch(32'h0000_0080, 0, 32'h0800_0080, 1'b0, 32'h0800_0080, 1'b0);

    // Reset during FILL: iREN drops immediately, cached lines are lost.
    dcif.imemREN  = 1'b1;
    dcif.imemaddr = 32'h0000_0040;
    cif.iwait     = 1'b1;
    @(negedge clk);
    #1;
    check("rstfill_iren_pre", 32'(cif.iREN), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rstfill_iren",  32'(cif.iREN), 32'd0);
    check("rstfill_iaddr", cif.iaddr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_fetch(32'h0000_0044, 0, 32'h1111_0044, 1'b0, 32'h1111_0044, 1'b0);
    do_fetch(32'h0000_0040, 2, 32'h2001_0005, 1'b0, 32'h2001_0005, 1'b0);

    // Randomized fetches against the reference model.
    do_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    for (int n = 0; n < 300; n++) begin
      a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 3) == 0) a = a | 32'hA000_0000;
      if ($urandom_range(0, 7) == 0) begin
        dcif.imemREN  = 1'b0;
        dcif.imemaddr = a;
        #1;
        check("idle_ihit", 32'(dcif.ihit), 32'd0);
        check("idle_load", dcif.imemload, 32'd0);
        check("idle_iren", 32'(cif.iREN), 32'd0);
        @(negedge clk);
      end else begin
        ix = int'(a[5:2]);
        eh = m_valid[ix] && (m_addr[ix] == a);
        ld = mem_word(a);
        do_fetch(a, int'($urandom_range(0, 3)), ld, eh, eh ? m_data[ix] : ld,
                 ($urandom_range(0, 3) == 0));
        m_valid[ix] = 1'b1;
        m_addr[ix]  = a;
        m_data[ix]  = ld;
      end
    end

`ifdef ICACHE_PERF_EN
    // One miss (whose post-fill cycle is itself a hit) plus two explicit hits: three hit cycles.
    do_reset();
    do_fetch(32'h0000_0040, 1, 32'h2001_0005, 1'b0, 32'h2001_0005, 1'b0);
    do_fetch(32'h0000_0040, 0, 32'h0, 1'b1, 32'h2001_0005, 1'b0);
    do_fetch(32'h0000_0040, 0, 32'h0, 1'b1, 32'h2001_0005, 1'b0);
    dcif.imemREN = 1'b0;
    #1;
    check("perf_miss", miss_count, 32'd1);
    check("perf_hit",  hit_count,  32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
